// File: rtl/bcp_pkg.sv
// rtl/bcp_pkg.sv - shared constants and FSM state encoding for bcp_controller
//
// Purpose : default sizing constants, the controller state enum and the
//           clause-address width helper shared by the interface and the top.
// Ports   : none (package).
package bcp_pkg;

  localparam int BCP_NV_DEFAULT = 8;
  localparam int BCP_NC_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EVAL   = 3'd2,
    ST_PUSH   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } bcp_state_e;

  // A single-clause table still needs a one-bit address.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcp_controller_if.sv
// rtl/bcp_controller_if.sv - clause-table read bus and implication stream
//
// Purpose : bundles the clause-table read port and the implication stream.
// Signals : cl_addr (AW) clause address; cl_pos/cl_neg (NV) clause literals,
//           valid one cycle after cl_addr; imp_valid/imp_var (NV one-hot)/
//           imp_val/imp_ready implication handshake.
// Modports: master = controller side, slave = clause memory / consumer side.
interface bcp_controller_if
  import bcp_pkg::*;
#(
  parameter int NV = BCP_NV_DEFAULT,
  parameter int NC = BCP_NC_DEFAULT
);
  localparam int AW = addr_width(NC);

  logic [AW-1:0] cl_addr;
  logic [NV-1:0] cl_pos;
  logic [NV-1:0] cl_neg;
  logic          imp_valid;
  logic [NV-1:0] imp_var;
  logic          imp_val;
  logic          imp_ready;

  modport master (
    output cl_addr,
    input  cl_pos, cl_neg,
    output imp_valid, imp_var, imp_val,
    input  imp_ready
  );

  modport slave (
    input  cl_addr,
    output cl_pos, cl_neg,
    input  imp_valid, imp_var, imp_val,
    output imp_ready
  );

endinterface

// File: rtl/implication_unit.sv
// rtl/implication_unit.sv - unit-clause detector
//
// Purpose : returns the single unassigned literal of a clause, or zero when
//           the clause has none or more than one unassigned literal.
// Ports   : free (NV) unassigned-variable mask; clause_mask (NV) variables
//           appearing in the clause; implication (NV) one-hot or zero.
module implication_unit #(
  parameter int NV = 8
) (
  input  logic [NV-1:0] free,
  input  logic [NV-1:0] clause_mask,
  output logic [NV-1:0] implication
);

  logic [NV-1:0] open_lits;
  logic          one_hot;

  assign open_lits = free & clause_mask;
  // Clearing the lowest set bit leaves zero only for a single set bit.
  assign one_hot = (open_lits != '0) && ((open_lits & (open_lits - NV'(1))) == '0);
  assign implication = one_hot ? open_lits : '0;

endmodule

// File: rtl/bcp_controller.sv
// rtl/bcp_controller.sv - Boolean constraint propagation controller
//
// Purpose : repeatedly scans a clause table, pushes unit implications onto a
//           stream and updates the assignment until a pass makes no change
//           or a clause is falsified.
// Ports   : clk, rst_n (async active-low); start; free_in/value_in (NV)
//           initial assignment; bus (bcp_controller_if.master) clause read
//           bus and implication stream; busy; done (1-cycle pulse);
//           conflict; conflict_idx (AW); free_out/value_out (NV).
// Options : BCP_STATS_EN adds imp_count (16) and pass_count (8), cleared on
//           start and saturating.
module bcp_controller
  import bcp_pkg::*;
#(
  parameter  int NV = BCP_NV_DEFAULT,
  parameter  int NC = BCP_NC_DEFAULT,
  localparam int AW = addr_width(NC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NV-1:0]     free_in,
  input  logic [NV-1:0]     value_in,
  bcp_controller_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              conflict,
  output logic [AW-1:0]     conflict_idx,
  output logic [NV-1:0]     free_out,
  output logic [NV-1:0]     value_out
`ifdef BCP_STATS_EN
  ,
  output logic [15:0]       imp_count,
  output logic [7:0]        pass_count
`endif
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_EVAL   = ST_EVAL;
  localparam logic [2:0] S_PUSH   = ST_PUSH;
  localparam logic [2:0] S_CHECK  = ST_CHECK;
  localparam logic [2:0] S_FINISH = ST_FINISH;

  logic [2:0]    state;
  logic [AW-1:0] idx;
  logic          changed;
  logic [NV-1:0] free_r;
  logic [NV-1:0] value_r;
  logic          imp_valid_r;
  logic [NV-1:0] imp_var_r;
  logic          imp_val_r;

  logic [NV-1:0] clause_mask;
  logic [NV-1:0] implication;
  logic          satisfied;
  logic          is_empty;
  logic          last_idx;
  logic [2:0]    adv_state;
  logic [AW-1:0] adv_idx;

  assign clause_mask = bus.cl_pos | bus.cl_neg;

  implication_unit #(.NV(NV)) u_imp (
    .free        (free_r),
    .clause_mask (clause_mask),
    .implication (implication)
  );

  assign satisfied = |((bus.cl_pos & ~free_r & value_r) |
                       (bus.cl_neg & ~free_r & ~value_r));
  // An all-zero table entry is an unused slot, not an empty (false) clause.
  assign is_empty  = (clause_mask == '0);
  assign last_idx  = (idx == AW'(NC - 1));
  assign adv_state = last_idx ? S_CHECK : S_FETCH;
  assign adv_idx   = last_idx ? idx : idx + AW'(1);

  assign bus.cl_addr   = idx;
  assign bus.imp_valid = imp_valid_r;
  assign bus.imp_var   = imp_var_r;
  assign bus.imp_val   = imp_val_r;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign free_out  = free_r;
  assign value_out = value_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      changed      <= 1'b0;
      free_r       <= '1;
      value_r      <= '0;
      conflict     <= 1'b0;
      conflict_idx <= '0;
      imp_valid_r  <= 1'b0;
      imp_var_r    <= '0;
      imp_val_r    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FETCH;
            free_r       <= free_in;
            value_r      <= value_in;
            conflict     <= 1'b0;
            conflict_idx <= '0;
            idx          <= '0;
            changed      <= 1'b0;
          end
        end
        S_FETCH: state <= S_EVAL;
        S_EVAL: begin
          if (is_empty || satisfied) begin
            state <= adv_state;
            idx   <= adv_idx;
          end else if ((clause_mask & free_r) == '0) begin
            conflict     <= 1'b1;
            conflict_idx <= idx;
            state        <= S_FINISH;
          end else if (implication != '0) begin
            imp_valid_r <= 1'b1;
            imp_var_r   <= implication;
            imp_val_r   <= |(implication & bus.cl_pos);
            state       <= S_PUSH;
          end else begin
            state <= adv_state;
            idx   <= adv_idx;
          end
        end
        S_PUSH: begin
          // Assignment only changes once the consumer has taken the implication.
          if (bus.imp_ready) begin
            imp_valid_r <= 1'b0;
            free_r      <= free_r & ~imp_var_r;
            value_r     <= imp_val_r ? (value_r | imp_var_r) : (value_r & ~imp_var_r);
            changed     <= 1'b1;
            state       <= adv_state;
            idx         <= adv_idx;
          end
        end
        S_CHECK: begin
          if (changed) begin
            idx     <= '0;
            changed <= 1'b0;
            state   <= S_FETCH;
          end else begin
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

`ifdef BCP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imp_count  <= '0;
      pass_count <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        imp_count  <= '0;
        pass_count <= '0;
      end
    end else begin
      if (state == S_PUSH && bus.imp_ready && imp_count != '1)
        imp_count <= imp_count + 16'd1;
      // Every completed pass goes through CHECK exactly once.
      if (state == S_CHECK && pass_count != '1)
        pass_count <= pass_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcp_controller.sv
// tb/tb_bcp_controller.sv - self-checking bench for bcp_controller
`timescale 1ns/1ps
module tb_bcp_controller;
  import bcp_pkg::*;

  localparam int NV = 8;
  localparam int NC = 2;
  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NV-1:0] free_in = '0;
  logic [NV-1:0] value_in = '0;
  logic          busy, done, conflict;
  logic [AW-1:0] conflict_idx;
  logic [NV-1:0] free_out, value_out;
`ifdef BCP_STATS_EN
  logic [15:0]   imp_count;
  logic [7:0]    pass_count;
`endif

  bcp_controller_if #(.NV(NV), .NC(NC)) bus ();

  bcp_controller #(.NV(NV), .NC(NC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .free_in      (free_in),
    .value_in     (value_in),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .conflict     (conflict),
    .conflict_idx (conflict_idx),
    .free_out     (free_out),
    .value_out    (value_out)
`ifdef BCP_STATS_EN
    ,
    .imp_count    (imp_count),
    .pass_count   (pass_count)
`endif
  );

  always #5 clk = ~clk;

  // Clause table with one cycle of read latency.
  logic [NV-1:0] mem_pos [NC];
  logic [NV-1:0] mem_neg [NC];
  always @(posedge clk) begin
    bus.cl_pos <= mem_pos[bus.cl_addr];
    bus.cl_neg <= mem_neg[bus.cl_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference model: propagate to a fixpoint directly from the clause rules.
  logic [NV-1:0] exp_var_q [$];
  bit            exp_val_q [$];
  logic [NV-1:0] exp_free, exp_value;
  bit            exp_conf;
  int            exp_cidx, exp_passes;

  task automatic model_run(input logic [NV-1:0] f0, input logic [NV-1:0] v0);
    logic [NV-1:0] f, v, pos, neg, open;
    bit changed, sat;
    f = f0; v = v0;
    exp_conf = 0; exp_cidx = 0; exp_passes = 0;
    exp_var_q.delete(); exp_val_q.delete();
    changed = 1;
    while (changed && !exp_conf) begin
      changed = 0;
      for (int c = 0; c < NC && !exp_conf; c++) begin
        pos  = mem_pos[c];
        neg  = mem_neg[c];
        sat  = ((pos & ~f & v) | (neg & ~f & ~v)) != 0;
        open = (pos | neg) & f;
        if ((pos | neg) != 0 && !sat) begin
          if (open == 0) begin
            exp_conf = 1; exp_cidx = c;
          end else if ($countones(open) == 1) begin
            exp_var_q.push_back(open);
            exp_val_q.push_back((open & pos) != 0);
            f = f & ~open;
            v = ((open & pos) != 0) ? (v | open) : (v & ~open);
            changed = 1;
          end
        end
      end
      if (!exp_conf) exp_passes++;
    end
    exp_free = f; exp_value = v;
  endtask

  // Compare process: consumer with configurable backpressure, checks every cycle.
  int stall_cfg = 0, stall_left = 0, xfer_cnt = 0, stall_cycles = 0, done_cnt = 0;
  bit prev_pending = 0, prev_done = 0, prev_val;
  logic [NV-1:0] prev_var;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.imp_ready = 1'b0;
      prev_pending = 0; prev_done = 0;
      stall_left = stall_cfg;
    end else begin
      if (prev_pending) begin
        check("hold_valid", bus.imp_valid, 1);
        check("hold_var", bus.imp_var, prev_var);
        check("hold_val", bus.imp_val, prev_val);
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", prev_done, 0);
      end
      prev_done = done;
      if (bus.imp_valid) begin
        check("imp_var_onehot", $countones(bus.imp_var), 1);
        if (stall_left > 0) begin
          bus.imp_ready = 1'b0; stall_left--; stall_cycles++;
        end else begin
          bus.imp_ready = 1'b1;
        end
        if (bus.imp_ready) begin
          xfer_cnt++;
          checks++;
          if (exp_var_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_imp: got var %0h with no implication expected", bus.imp_var);
          end else begin
            if (bus.imp_var !== exp_var_q[0] || bus.imp_val !== exp_val_q[0]) begin
              errors++;
              $display("FAIL imp_item: got var %0h val %0d expected var %0h val %0d",
                       bus.imp_var, bus.imp_val, exp_var_q[0], exp_val_q[0]);
            end
            void'(exp_var_q.pop_front());
            void'(exp_val_q.pop_front());
          end
          stall_left = stall_cfg;
        end
        prev_pending = !bus.imp_ready;
        prev_var = bus.imp_var;
        prev_val = bus.imp_val;
      end else begin
        bus.imp_ready = 1'b0;
        prev_pending = 0;
      end
    end
  end

  task automatic set_clauses(input logic [NV-1:0] p0, input logic [NV-1:0] n0,
                             input logic [NV-1:0] p1, input logic [NV-1:0] n1);
    mem_pos[0] = p0; mem_neg[0] = n0;
    mem_pos[1] = p1; mem_neg[1] = n1;
  endtask

  task automatic begin_run(input logic [NV-1:0] f, input logic [NV-1:0] v, input int stall);
    model_run(f, v);
    stall_cfg = stall; stall_left = stall;
    xfer_cnt = 0; stall_cycles = 0; done_cnt = 0;
    @(negedge clk);
    free_in = f; value_in = v; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input string tag, input logic [NV-1:0] f, input logic [NV-1:0] v,
                        input int stall, input bit second_start);
    bit got_done;
    begin_run(f, v, stall);
    if (second_start) begin
      @(negedge clk);
      check({tag, "_busy_in_eval"}, busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got_done = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      @(negedge clk);
      if (done) got_done = 1;
    end
    check({tag, "_done_seen"}, got_done, 1);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_conflict"}, conflict, exp_conf);
    if (exp_conf) check({tag, "_conflict_idx"}, conflict_idx, exp_cidx);
    check({tag, "_free_out"}, free_out, exp_free);
    check({tag, "_value_out"}, value_out, exp_value);
    check({tag, "_imps_left"}, exp_var_q.size(), 0);
`ifdef BCP_STATS_EN
    check({tag, "_pass_count"}, pass_count, exp_passes);
`endif
  endtask

  initial begin
    bit saw_valid;
    set_clauses(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conflict", conflict, 0);
    check("rst_imp_valid", bus.imp_valid, 0);
    check("rst_cl_addr", bus.cl_addr, 0);
    check("rst_conflict_idx", conflict_idx, 0);
    check("rst_imp_var", bus.imp_var, 0);
    check("rst_free_out", free_out, 8'hff);
    check("rst_value_out", value_out, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single implication.
    set_clauses(8'h03, 8'h00, 8'h00, 8'h00);
    do_run("single", 8'h01, 8'h00, 0, 0);
    check("single_lit_value", value_out, 8'h01);
    check("single_lit_free", free_out, 8'h00);
    check("single_lit_xfers", xfer_cnt, 1);

    // Conflict on clause 0.
    set_clauses(8'h03, 8'h00, 8'h00, 8'h00);
    do_run("conflict", 8'h00, 8'h00, 0, 0);
    check("conflict_lit", conflict, 1);
    check("conflict_lit_idx", conflict_idx, 0);
    check("conflict_lit_xfers", xfer_cnt, 0);

    // Chained implications over three passes.
    set_clauses(8'h02, 8'h01, 8'h01, 8'h00);
    do_run("chain", 8'h03, 8'h00, 0, 0);
    check("chain_lit_value", value_out, 8'h03);
    check("chain_lit_xfers", xfer_cnt, 2);
    check("chain_lit_passes", exp_passes, 3);
`ifdef BCP_STATS_EN
    check("chain_lit_pass_count", pass_count, 8'd3);
    check("chain_lit_imp_count", imp_count, 16'd2);
`endif

    // Backpressure: consumer holds off for 5 cycles.
    set_clauses(8'h03, 8'h00, 8'h00, 8'h00);
    do_run("bp", 8'h01, 8'h00, 5, 0);
    check("bp_stall_cycles", stall_cycles, 5);
    check("bp_xfers", xfer_cnt, 1);
    check("bp_lit_value", value_out, 8'h01);

    // Reset while an implication is waiting in PUSH.
    begin_run(8'h01, 8'h00, 100);
    saw_valid = 0;
    for (int i = 0; i < 50 && !saw_valid; i++) begin
      @(negedge clk);
      if (bus.imp_valid) saw_valid = 1;
    end
    check("mid_rst_reached_push", saw_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_imp_valid", bus.imp_valid, 0);
    check("mid_rst_free_out", free_out, 8'hff);
    check("mid_rst_value_out", value_out, 8'h00);
    stall_cfg = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_run("rerun", 8'h01, 8'h00, 0, 0);
    check("rerun_lit_value", value_out, 8'h01);
    check("rerun_lit_xfers", xfer_cnt, 1);

    // Second start while busy in EVAL is ignored.
    do_run("dblstart", 8'h01, 8'h00, 0, 1);
    check("dblstart_lit_xfers", xfer_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcp_controller.md
BCP_CONTROLLER -- requirements
Module: bcp_controller

Interface
REQ-001 SHALL have parameter NV, default 8: number of variables (width of free/value/mask vectors).
REQ-002 SHALL have parameter NC, default 16: number of clauses scanned per pass; AW = clog2(NC).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: begins propagation; sampled only in IDLE.
REQ-006 SHALL have ports free_in and value_in, input, NV each: initial assignment, loaded on accepted start; free=1 means unassigned.
REQ-007 SHALL have port cl_addr, output, AW: clause-table read address.
REQ-008 SHALL have ports cl_pos and cl_neg, input, NV each: clause literals, valid one cycle after cl_addr.
REQ-009 SHALL have ports imp_valid (output, 1), imp_var (output, NV, one-hot), imp_val (output, 1) and imp_ready (input, 1): implication stream.
REQ-010 SHALL have ports busy, done (1-cycle pulse), conflict, conflict_idx (AW), free_out and value_out (NV each), all outputs.

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, EVAL, PUSH, CHECK, FINISH.
REQ-012 SHALL go IDLE->FETCH on start, load the free/value registers, clear conflict, and set clause index and changed flag to 0.
REQ-013 SHALL drive cl_addr with the clause index in FETCH and go to EVAL the next cycle.
REQ-014 SHALL in EVAL form clause_mask = cl_pos|cl_neg and feed free and clause_mask to implication_unit.
REQ-015 SHALL treat a clause as satisfied when its masked assigned literals hold the literal's polarity: pos & ~free & value, or neg & ~free & ~value, nonzero.
REQ-016 SHALL, for an unsatisfied clause with (clause_mask & free) == 0, set conflict, set conflict_idx = index, and go to FINISH.
REQ-017 SHALL, for an unsatisfied clause where implication is nonzero, present imp_var = implication and imp_val = |(implication & cl_pos), then go to PUSH.
REQ-018 SHALL, for an unsatisfied clause where implication is zero, or for a satisfied clause, advance the index.
REQ-019 SHALL in PUSH hold imp_valid, imp_var and imp_val stable until imp_ready.
REQ-020 SHALL, on the PUSH handshake, clear the free bit, write the value bit, set changed, and advance the index.
REQ-021 SHALL advance the index by going to FETCH with index+1, or to CHECK when index = NC-1.
REQ-022 SHALL in CHECK restart the pass at index 0 with changed cleared if changed = 1, and go to FINISH otherwise.
REQ-023 SHALL in FINISH pulse done for one cycle and return to IDLE; conflict and conflict_idx hold until the next start.
REQ-024 SHALL keep busy = 1 in every state except IDLE.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL limit throughput to 2 cycles per non-implying clause and 3+stall cycles per implying clause.

Reset
REQ-027 SHALL on rst_n low immediately force state=IDLE; imp_valid, busy, done, conflict = 0; cl_addr, conflict_idx, imp_var = 0; free_out = all ones; value_out = 0.
REQ-028 SHALL discard an in-flight implication when reset asserts mid-scan; no partial update survives.

Configuration
REQ-029 SHALL, with BCP_STATS_EN defined, add outputs imp_count (16 bits) and pass_count (8 bits), both cleared on start, saturating, and holding after done.
REQ-030 SHALL, without BCP_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-031 SHALL define the FSM state enum and default NV/NC constants in shared package bcp_pkg.
REQ-032 SHALL instantiate existing module implication_unit once, as the only sub-module (instance u_imp).

Verification (NV=8, NC=2 unless noted)
REQ-033 SHALL cover single implication: clause0 pos=00000011, free_in=00000001, value_in=0, clause1 empty -> one imp_var=00000001, imp_val=1; done; conflict=0; value_out=00000001.
REQ-034 SHALL cover conflict: clause0 pos=00000011, free_in=0, value_in=0 -> conflict=1, conflict_idx=0, no imp_valid, done pulse.
REQ-035 SHALL cover chained implications: clause0 neg=00000001, pos=00000010; clause1 pos=00000001; free_in=00000011 -> x0=1 pushed, then x1=1; three passes (pass_count=3 with BCP_STATS_EN).
REQ-036 SHALL cover backpressure: REQ-033 stimulus with imp_ready low for 5 cycles -> imp_valid, imp_var and imp_val stable throughout; exactly one transfer.
REQ-037 SHALL cover reset mid-scan: rst_n low during PUSH -> same cycle busy=0, imp_valid=0, free_out=11111111; a later start rerun gives REQ-033 results.
REQ-038 SHALL cover start while busy: second start during EVAL -> ignored; exactly one done pulse.
